regfile_checker: RTL and testbench

Synthesizable run-and-verify engine that sits between the pipelined processor and the register file. After `start` it lets the processor run for a programmable number of cycles and time-stamps every register write into a trace FIFO. It then freezes the processor, takes over read port A of the register file, and compares every register against an expected-value memory. It reports a pass/fail verdict, an error count and the first mismatch.

---
 rtl/regfile_checker_if.sv | 24 ++
 rtl/regfile_checker.sv | 189 ++++++++++++++++++
 tb/tb_regfile_checker.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_checker_if.sv
// Trace stream between regfile_checker and the trace consumer.
// master (checker): drives trace_valid/cycle/reg/data, receives trace_ready.
// slave (consumer): receives the head entry, drives trace_ready.
interface regfile_checker_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 5,
    parameter int unsigned CYCLE_BITS = 10
);
    logic                  trace_valid;
    logic                  trace_ready;
    logic [CYCLE_BITS-1:0] trace_cycle;
    logic [ADDR_BITS-1:0]  trace_reg;
    logic [DATA_WIDTH-1:0] trace_data;

    modport master (
        output trace_valid, trace_cycle, trace_reg, trace_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_cycle, trace_reg, trace_data,
        output trace_ready
    );
endinterface

// File: rtl/regfile_checker.sv
// Run-and-verify engine between the processor and its register file.
// Lets the processor run num_cycles cycles while time-stamping register
// writes into a trace FIFO, then freezes it, scans every register through
// read port A against an expected-value memory and reports the verdict.
// Ports:
//   clock, reset           : clock, async active-high reset
//   start, num_cycles      : launch a run of the given length
//   cpu_rwe/rd/wdata       : processor write port (traced in RUN)
//   cpu_rs1, rs1_out, regA : read port A, taken over during SCAN
//   exp_addr, exp_data     : expected-value memory lookup
//   cpu_hold               : freeze processor (SCAN/DONE)
//   trace                  : trace FIFO head stream (master side)
//   trace_overflow         : sticky, a traced write was dropped
//   busy, done, pass       : status
//   error_count, first_err_reg/exp/act : scan results
module regfile_checker #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_BITS   = 5,
    parameter int unsigned CYCLE_BITS  = 10,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter bit          SKIP_R0     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CYCLE_BITS-1:0] num_cycles,
    input  logic                  cpu_rwe,
    input  logic [ADDR_BITS-1:0]  cpu_rd,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [ADDR_BITS-1:0]  cpu_rs1,
    output logic [ADDR_BITS-1:0]  rs1_out,
    input  logic [DATA_WIDTH-1:0] regA,
    output logic [ADDR_BITS-1:0]  exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  cpu_hold,
    regfile_checker_if.master     trace,
    output logic                  trace_overflow,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS:0]    error_count,
    output logic [ADDR_BITS-1:0]  first_err_reg,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_act
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_BITS;
    localparam int unsigned PTR_W    = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ENTRY_W  = CYCLE_BITS + ADDR_BITS + DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [CYCLE_BITS-1:0] cnt_q, cnt_d;
    logic [CYCLE_BITS-1:0] ncyc_q, ncyc_d;
    logic [ADDR_BITS-1:0]  scan_idx_q, scan_idx_d;
    logic [ADDR_BITS:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_BITS-1:0]  fe_reg_q, fe_reg_d;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_WIDTH-1:0] fe_act_q, fe_act_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fcount_q, fcount_d;
    logic                  ovf_q, ovf_d;
    logic [ENTRY_W-1:0]    mem_q [TRACE_DEPTH];

    logic                  push_req, push_en, pop_en, full;
    logic [ENTRY_W-1:0]    entry_d;

    // Next-state, FIFO bookkeeping and scan comparison
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ncyc_d     = ncyc_q;
        scan_idx_d = scan_idx_q;
        err_cnt_d  = err_cnt_q;
        fe_reg_d   = fe_reg_q;
        fe_exp_d   = fe_exp_q;
        fe_act_d   = fe_act_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcount_d   = fcount_q;
        ovf_d      = ovf_q;
        entry_d    = {cnt_q, cpu_rd, cpu_wdata};

        full     = (fcount_q == CNT_W'(TRACE_DEPTH));
        pop_en   = (fcount_q != '0) && trace.trace_ready;
        push_req = (state_q == S_RUN) && cpu_rwe && !(SKIP_R0 && (cpu_rd == '0));
        // A pop in the same cycle frees the slot a full-FIFO push needs
        push_en  = push_req && (!full || pop_en);

        if (push_req && full && !pop_en) ovf_d = 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push_en && !pop_en)      fcount_d = fcount_q + CNT_W'(1);
        else if (!push_en && pop_en) fcount_d = fcount_q - CNT_W'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ncyc_d     = num_cycles;
                    cnt_d      = '0;
                    scan_idx_d = '0;
                    err_cnt_d  = '0;
                    fe_reg_d   = '0;
                    fe_exp_d   = '0;
                    fe_act_d   = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    fcount_d   = '0;
                    ovf_d      = 1'b0;
                    state_d    = (num_cycles == '0) ? S_SCAN : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CYCLE_BITS'(1);
                if (cnt_q == ncyc_q - CYCLE_BITS'(1)) begin
                    scan_idx_d = '0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (regA != exp_data) begin
                    err_cnt_d = err_cnt_q + (ADDR_BITS + 1)'(1);
                    // Zero count so far means this is the first mismatch
                    if (err_cnt_q == '0) begin
                        fe_reg_d = scan_idx_q;
                        fe_exp_d = exp_data;
                        fe_act_d = regA;
                    end
                end
                if (scan_idx_q == ADDR_BITS'(NUM_REGS - 1)) state_d = S_DONE;
                else scan_idx_d = scan_idx_q + ADDR_BITS'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ncyc_q     <= '0;
            scan_idx_q <= '0;
            err_cnt_q  <= '0;
            fe_reg_q   <= '0;
            fe_exp_q   <= '0;
            fe_act_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcount_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ncyc_q     <= ncyc_d;
            scan_idx_q <= scan_idx_d;
            err_cnt_q  <= err_cnt_d;
            fe_reg_q   <= fe_reg_d;
            fe_exp_q   <= fe_exp_d;
            fe_act_q   <= fe_act_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcount_q   <= fcount_d;
            ovf_q      <= ovf_d;
        end
    end

    // Trace storage; contents are only meaningful under the valid count
    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_ptr_q] <= entry_d;
    end

    assign trace.trace_valid = (fcount_q != '0);
    assign {trace.trace_cycle, trace.trace_reg, trace.trace_data} = mem_q[rd_ptr_q];

    assign rs1_out        = (state_q == S_SCAN) ? scan_idx_q : cpu_rs1;
    assign exp_addr       = (state_q == S_SCAN) ? scan_idx_q : '0;
    assign cpu_hold       = (state_q == S_SCAN) || (state_q == S_DONE);
    assign busy           = (state_q == S_RUN) || (state_q == S_SCAN);
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_cnt_q == '0);
    assign trace_overflow = ovf_q;
    assign error_count    = err_cnt_q;
    assign first_err_reg  = fe_reg_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_act  = fe_act_q;
endmodule

// File: tb/tb_regfile_checker.sv
// Bench for regfile_checker: directed runs, a time-based behavioural model
// compared every cycle, plus literal expectations for each scenario.
module tb_regfile_checker;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 10;
    localparam int TD = 16;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_cycles;
    logic          cpu_rwe;
    logic [AW-1:0] cpu_rd;
    logic [DW-1:0] cpu_wdata;
    logic [AW-1:0] cpu_rs1;
    logic [AW-1:0] rs1_out;
    logic [DW-1:0] regA;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          cpu_hold, trace_overflow, busy, done, pass;
    logic [AW:0]   error_count;
    logic [AW-1:0] first_err_reg;
    logic [DW-1:0] first_err_exp, first_err_act;
    logic          trace_ready;

    logic [DW-1:0] rf   [NR];
    logic [DW-1:0] expm [NR];

    regfile_checker_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .CYCLE_BITS(CW)) tif ();
    assign tif.trace_ready = trace_ready;
    assign regA     = rf[rs1_out];
    assign exp_data = expm[exp_addr];

    regfile_checker #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .CYCLE_BITS(CW),
                      .TRACE_DEPTH(TD), .SKIP_R0(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
        .cpu_rs1(cpu_rs1), .rs1_out(rs1_out), .regA(regA),
        .exp_addr(exp_addr), .exp_data(exp_data), .cpu_hold(cpu_hold),
        .trace(tif), .trace_overflow(trace_overflow), .busy(busy),
        .done(done), .pass(pass), .error_count(error_count),
        .first_err_reg(first_err_reg), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Behavioural model: phase is derived from edges elapsed since start
    typedef struct { logic [CW-1:0] c; logic [AW-1:0] r; logic [DW-1:0] d; } tr_t;
    tr_t           mq[$];
    tr_t           ent;
    bit            m_started, m_ovf, m_pop, m_run, m_scan, m_idle;
    int            m_t, m_n, m_err, m_sz, m_idx;
    logic [AW-1:0] m_fr;
    logic [DW-1:0] m_fe, m_fa;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_started = 0; m_t = 0; m_n = 0; m_ovf = 0; m_err = 0;
            m_fr = '0; m_fe = '0; m_fa = '0;
            mq.delete();
        end else begin
            m_sz   = mq.size();
            m_pop  = trace_ready && (m_sz > 0);
            m_run  = m_started && (m_t < m_n);
            m_scan = m_started && (m_t >= m_n) && (m_t < m_n + NR);
            m_idle = !m_started || (m_t >= m_n + NR);
            if (m_pop) mq.delete(0);
            if (m_run && cpu_rwe && cpu_rd != '0) begin
                if (m_sz == TD && !m_pop) m_ovf = 1;
                else begin
                    ent.c = CW'(m_t); ent.r = cpu_rd; ent.d = cpu_wdata;
                    mq.push_back(ent);
                end
            end
            if (m_scan) begin
                m_idx = m_t - m_n;
                if (rf[AW'(m_idx)] !== expm[AW'(m_idx)]) begin
                    if (m_err == 0) begin
                        m_fr = AW'(m_idx); m_fe = expm[AW'(m_idx)]; m_fa = rf[AW'(m_idx)];
                    end
                    m_err++;
                end
            end
            if (m_idle && start) begin
                m_started = 1; m_t = 0; m_n = int'(num_cycles);
                m_ovf = 0; m_err = 0; m_fr = '0; m_fe = '0; m_fa = '0;
                mq.delete();
            end else if (m_started && m_t < 5000) m_t++;
        end
    end

    // Per-cycle comparison against the model
    bit e_scan, e_done, e_run;
    always @(negedge clock) begin
        e_run  = m_started && (m_t < m_n);
        e_scan = m_started && (m_t >= m_n) && (m_t < m_n + NR);
        e_done = m_started && (m_t >= m_n + NR);
        chk("busy", 64'(busy), 64'(e_run || e_scan));
        chk("done", 64'(done), 64'(e_done));
        chk("cpu_hold", 64'(cpu_hold), 64'(e_scan || e_done));
        chk("pass", 64'(pass), 64'(e_done && m_err == 0));
        chk("rs1_out", 64'(rs1_out), e_scan ? 64'(m_t - m_n) : 64'(cpu_rs1));
        chk("exp_addr", 64'(exp_addr), e_scan ? 64'(m_t - m_n) : 64'(0));
        chk("error_count", 64'(error_count), 64'(m_err));
        chk("first_err_reg", 64'(first_err_reg), 64'(m_fr));
        chk("first_err_exp", 64'(first_err_exp), 64'(m_fe));
        chk("first_err_act", 64'(first_err_act), 64'(m_fa));
        chk("trace_overflow", 64'(trace_overflow), 64'(m_ovf));
        chk("trace_valid", 64'(tif.trace_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("trace_head", {22'(tif.trace_cycle), 5'(tif.trace_reg), tif.trace_data},
                {22'(mq[0].c), 5'(mq[0].r), mq[0].d});
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic launch(input int n, output int s);
        num_cycles = CW'(n);
        start = 1'b1;
        step();
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int s, output int edges);
        while (!done && (cyc - s) < 300) step();
        if (!done) chk("done_timeout", 64'(0), 64'(1));
        edges = cyc - s + 1;
    endtask

    task automatic pop_all(output int n, output int last_c, output int last_d);
        n = 0; last_c = -1; last_d = -1;
        trace_ready = 1'b1;
        while (tif.trace_valid && n < 40) begin
            last_c = int'(tif.trace_cycle);
            last_d = int'(tif.trace_data);
            step();
            n++;
        end
        trace_ready = 1'b0;
    endtask

    int s, edges, n, lc, ld;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_cycles = '0; cpu_rwe = 1'b0;
        cpu_rd = '0; cpu_wdata = '0; cpu_rs1 = 5'd9; trace_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin rf[i] = '0; expm[i] = '0; end
        repeat (2) step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hold", 64'(cpu_hold), 64'(0));
        chk("rst_rs1", 64'(rs1_out), 64'(9));
        chk("rst_valid", 64'(tif.trace_valid), 64'(0));
        reset = 1'b0;
        step();

        // 1: traced run, r0 write skipped, clean scan
        rf[3] = 32'd5; expm[3] = 32'd5;
        launch(8, s);
        step(); step();
        cpu_rwe = 1'b1; cpu_rd = 5'd3; cpu_wdata = 32'd5; step();
        cpu_rwe = 1'b0; step();
        cpu_rwe = 1'b1; cpu_rd = 5'd0; cpu_wdata = 32'd9; step();
        cpu_rwe = 1'b0;
        wait_done(s, edges);
        chk("t1_latency", 64'(edges), 64'(41));
        chk("t1_pass", 64'(pass), 64'(1));
        chk("t1_errs", 64'(error_count), 64'(0));
        chk("t1_head", {22'(tif.trace_cycle), 5'(tif.trace_reg), tif.trace_data},
            {22'd2, 5'd3, 32'd5});
        pop_all(n, lc, ld);
        chk("t1_entries", 64'(n), 64'(1));

        // 2: two mismatches; a start pulse mid-run is ignored
        rf[7] = 32'd12; expm[7] = 32'd10; rf[20] = 32'd1; expm[20] = 32'd2;
        cpu_rs1 = 5'd4;
        launch(3, s);
        step();
        num_cycles = '0; start = 1'b1; step(); start = 1'b0;
        wait_done(s, edges);
        chk("t2_latency", 64'(edges), 64'(36));
        chk("t2_errs", 64'(error_count), 64'(2));
        chk("t2_fe_reg", 64'(first_err_reg), 64'(7));
        chk("t2_fe_exp", 64'(first_err_exp), 64'(10));
        chk("t2_fe_act", 64'(first_err_act), 64'(12));
        chk("t2_pass", 64'(pass), 64'(0));

        // 3: 20 writes into a 16-deep trace with no pops
        rf[7] = 32'd10; rf[20] = 32'd2;
        launch(20, s);
        for (int i = 0; i < 20; i++) begin
            cpu_rwe = 1'b1; cpu_rd = AW'(i + 1); cpu_wdata = DW'(100 + i); cpu_rs1 = AW'(i);
            step();
        end
        cpu_rwe = 1'b0;
        chk("t3_ovf", 64'(trace_overflow), 64'(1));
        chk("t3_head", {22'(tif.trace_cycle), 5'(tif.trace_reg), tif.trace_data},
            {22'd0, 5'd1, 32'd100});
        pop_all(n, lc, ld);
        chk("t3_kept", 64'(n), 64'(16));
        chk("t3_last", 64'(lc), 64'(15));
        wait_done(s, edges);
        chk("t3_latency", 64'(edges), 64'(53));

        // 4: push and pop together on a full trace
        launch(20, s);
        for (int i = 0; i < 16; i++) begin
            cpu_rwe = 1'b1; cpu_rd = AW'(i + 1); cpu_wdata = DW'(200 + i);
            step();
        end
        cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_wdata = 32'd777; trace_ready = 1'b1;
        step();
        cpu_rwe = 1'b0; trace_ready = 1'b0;
        chk("t4_ovf", 64'(trace_overflow), 64'(0));
        chk("t4_head", 64'(tif.trace_cycle), 64'(1));
        pop_all(n, lc, ld);
        chk("t4_count", 64'(n), 64'(16));
        chk("t4_last_c", 64'(lc), 64'(16));
        chk("t4_last_d", 64'(ld), 64'(777));
        wait_done(s, edges);

        // 5: zero-length run goes straight to scan
        launch(0, s);
        chk("t5_hold", 64'(cpu_hold), 64'(1));
        chk("t5_busy", 64'(busy), 64'(1));
        chk("t5_rs1", 64'(rs1_out), 64'(0));
        wait_done(s, edges);
        chk("t5_latency", 64'(edges), 64'(33));

        // 6: reset at scan index 10, then a fresh run
        rf[2] = 32'd99;
        cpu_rs1 = 5'd17;
        launch(2, s);
        repeat (12) step();
        chk("t6_idx", 64'(rs1_out), 64'(10));
        chk("t6_errs_mid", 64'(error_count), 64'(1));
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_hold", 64'(cpu_hold), 64'(0));
        chk("t6_rst_rs1", 64'(rs1_out), 64'(17));
        chk("t6_rst_eaddr", 64'(exp_addr), 64'(0));
        chk("t6_rst_errs", 64'(error_count), 64'(0));
        step();
        reset = 1'b0;
        step();
        launch(1, s);
        wait_done(s, edges);
        chk("t6_latency", 64'(edges), 64'(34));
        chk("t6_errs", 64'(error_count), 64'(1));
        chk("t6_fe_reg", 64'(first_err_reg), 64'(2));
        chk("t6_fe_act", 64'(first_err_act), 64'(99));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
